prog_loader: RTL and testbench

- Writer side of the instruction-memory interface: fills the CPU's instruction memory, which the control FSM only reads during FETCH.
- Receives a framed byte stream over a valid/ready handshake and writes the payload into instruction memory word by word.
- Verifies an 8-bit checksum over the payload.
- Holds the CPU (PC and control FSM) in hold during and after reset; releases it with a start pulse after a good load.

---
 rtl/prog_loader.sv | 193 +++++++++++++++++++
 tb/tb_prog_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: writer side of the CPU instruction-memory interface.
//
// Receives a framed byte stream (SYNC, LEN, LEN payload bytes, CHK) over a
// valid/ready handshake. Each payload byte is written to instruction memory
// one cycle after it is accepted. CHK is the 8-bit sum of the payload bytes.
// The CPU is held off (cpu_hold) from reset and throughout every load. After
// a load whose checksum matches, the loader pulses cpu_start and releases
// cpu_hold in that same cycle.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   in_valid/in_data source byte stream
//   in_ready         loader accepts a byte this cycle (decoded from state)
//   imem_we/addr/wdata  instruction-memory write port (registered)
//   cpu_hold         holds the CPU PC/control FSM while high
//   cpu_start        one-cycle pulse after a successful load
//   busy             a frame is in progress
//   done / err       sticky status of the last frame
module prog_loader #(
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 8,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          cpu_hold,
    output logic          cpu_start,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned CAP = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    // Length and index are one bit wider than the address so that a frame
    // filling the whole memory (LEN = 2^AW) terminates instead of wrapping.
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [DW-1:0] imem_wdata_q, imem_wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          cpu_start_q, cpu_start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic [AW:0]   idx_inc;

    // Ready is low for the single DONE cycle and while reset is asserted.
    assign in_ready = !rst && (state_q != S_DONE);
    assign accept   = in_valid && in_ready;
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        // NOTE: every _d starts from its _q so that no path through the case
        // leaves a signal unassigned; this is what keeps the block latch-free.
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        cpu_start_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE: begin
                // A non-SYNC byte is consumed and dropped with flags untouched.
                if (accept && in_data == DW'(SYNC)) begin
                    state_d    = S_LEN;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data == '0 || 32'(in_data) > CAP) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                        len_d   = (AW+1)'(in_data);
                        idx_d   = '0;
                        sum_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q[AW-1:0];
                    imem_wdata_d = in_data;
                    idx_d        = idx_inc;
                    sum_d        = sum_q + 8'(in_data);
                    if (idx_inc == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (8'(in_data) == sum_q) begin
                        // Start pulse and hold release land in the DONE cycle.
                        state_d     = S_DONE;
                        cpu_start_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        // Partial image stays in memory; hold stays asserted.
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: only control state needs a reset value; len/idx/sum are
            // reset here too so a mid-frame reset leaves nothing stale.
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            cpu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values.
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            cpu_start_q  <= cpu_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign cpu_start  = cpu_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. Stimulus pushes each expected memory write
// (address, data, cycle) into a queue at the edge where the byte is accepted.
// A negedge monitor pops and compares on every imem_we and also validates
// every cpu_start pulse.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [4:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_hold;
    logic       cpu_start;
    logic       busy;
    logic       done;
    logic       err;

    prog_loader #(.AW(5), .DW(8), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .cpu_start  (cpu_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t wq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  starts_seen = 0;
    int  starts_exp = 0;
    bit  prev_start = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the queue, including the
    // cycle it appears in (exactly one cycle after the accepting edge).
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (imem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", imem_addr, imem_wdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("write_addr", 32'(imem_addr), 32'(e.addr));
                    check("write_data", 32'(imem_wdata), 32'(e.data));
                    check("write_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (cpu_start) begin
                starts_seen++;
                check("start_hold_low", 32'(cpu_hold), 32'd0);
                check("start_done", 32'(done), 32'd1);
                check("start_single_cycle", 32'(prev_start), 32'd0);
            end
            prev_start = cpu_start;
        end
    end

    // Present a byte and wait (bounded) for the accepting edge. When wr is set
    // the byte is expected at address a in the cycle right after acceptance.
    task automatic send(input logic [7:0] b, input bit wr, input int a);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            if (wr) wq.push_back('{addr: 5'(a), data: b, cyc: cyc});
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_frame(input string name);
        idle(3);
        check({name, "_queue_empty"}, 32'(wq.size()), 32'd0);
        check({name, "_starts"}, 32'(starts_seen), 32'(starts_exp));
    endtask

    task automatic check_flags(input string name, input bit h, input bit b, input bit d, input bit e);
        check({name, "_hold"}, 32'(cpu_hold), 32'(h));
        check({name, "_busy"}, 32'(busy), 32'(b));
        check({name, "_done"}, 32'(done), 32'(d));
        check({name, "_err"}, 32'(err), 32'(e));
    endtask

    task automatic check_reset_outputs(input string name);
        check_flags(name, 1'b1, 1'b0, 1'b0, 1'b0);
        check({name, "_we"}, 32'(imem_we), 32'd0);
        check({name, "_start"}, 32'(cpu_start), 32'd0);
        check({name, "_addr"}, 32'(imem_addr), 32'd0);
        check({name, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({name, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // 1: good frame, in_valid held high throughout.
        send(8'hA5, 0, 0);
        send(8'h03, 0, 0);
        send(8'h41, 1, 0);
        send(8'hA2, 1, 1);
        send(8'hE0, 1, 2);
        send(8'hC3, 0, 0);
        starts_exp++;
        end_frame("t1");
        check_flags("t1", 1'b0, 1'b0, 1'b1, 1'b0);

        // 2: same frame, bad checksum. SYNC re-asserts hold immediately.
        send(8'hA5, 0, 0);
        check_flags("t2_sync", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h03, 0, 0);
        send(8'h41, 1, 0);
        send(8'hA2, 1, 1);
        send(8'hE0, 1, 2);
        send(8'hC4, 0, 0);
        end_frame("t2");
        check_flags("t2", 1'b1, 1'b0, 1'b0, 1'b1);

        // 3: junk ignored in IDLE, then LEN=0 rejected.
        send(8'h00, 0, 0);
        send(8'hFF, 0, 0);
        check_flags("t3_junk", 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'hA5, 0, 0);
        send(8'h00, 0, 0);
        end_frame("t3");
        check_flags("t3", 1'b1, 1'b0, 1'b0, 1'b1);

        // 4: full-capacity frame, 32 bytes of 01, CHK 20.
        send(8'hA5, 0, 0);
        send(8'h20, 0, 0);
        for (int i = 0; i < 32; i++) send(8'h01, 1, i);
        check("t4_ready_in_check", 32'(in_ready), 32'd1);
        check("t4_busy_in_check", 32'(busy), 32'd1);
        send(8'h20, 0, 0);
        starts_exp++;
        end_frame("t4");
        check_flags("t4", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_last_addr", 32'(imem_addr), 32'd31);

        // 5: in_valid toggled; SYNC value inside payload is plain data.
        send(8'hA5, 0, 0); idle(1);
        send(8'h02, 0, 0); idle(1);
        send(8'hA5, 1, 0); idle(1);
        send(8'h07, 1, 1); idle(1);
        send(8'hAC, 0, 0);
        starts_exp++;
        end_frame("t5");
        check_flags("t5", 1'b0, 1'b0, 1'b1, 1'b0);

        // 6: reset mid-frame, then a clean reload from address 0.
        send(8'hA5, 0, 0);
        send(8'h04, 0, 0);
        send(8'h11, 1, 0);
        send(8'h22, 0, 0);  // write of this byte is cancelled by reset
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        send(8'hA5, 0, 0);
        send(8'h02, 0, 0);
        send(8'h10, 1, 0);
        send(8'h20, 1, 1);
        send(8'h30, 0, 0);
        starts_exp++;
        end_frame("t6");
        check_flags("t6", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
